// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU constants used by the fetch unit and program loader
package cpu_pkg;

  localparam int IMEM_ADDR_W = 8;
  localparam int IMEM_DATA_W = 16;

  localparam logic [7:0] LOAD_SYNC_BYTE = 8'hA5;

  localparam logic [3:0] OP_JMP  = 4'h8;
  localparam logic [3:0] OP_BZ   = 4'h9;
  localparam logic [3:0] OP_BN   = 4'hA;
  localparam logic [3:0] OP_HALT = 4'hC;

endpackage

// File: rtl/prog_load_ctrl_if.sv
// rtl/prog_load_ctrl_if.sv - byte stream handshake from the receiver into the loader
interface prog_load_ctrl_if;

  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_ready;

  modport master (output rx_valid, output rx_data, input rx_ready);
  modport slave  (input rx_valid, input rx_data, output rx_ready);

endinterface

// File: rtl/prog_load_ctrl_idle_timer.sv
// rtl/prog_load_ctrl_idle_timer.sv - saturating idle-cycle counter for frame abort
module idle_timer #(
  parameter int TIMEOUT = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int WIDTH = $clog2(TIMEOUT + 1);

  logic [WIDTH-1:0] count;

  assign expired = (count == WIDTH'(TIMEOUT));

  // count idle cycles, saturating at TIMEOUT so expired stays asserted
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/prog_load_ctrl.sv
// rtl/prog_load_ctrl.sv - loads instruction memory from a framed byte stream while the CPU is held
module prog_load_ctrl
  import cpu_pkg::*;
#(
  parameter int         ADDR_W    = IMEM_ADDR_W,
  parameter int         DATA_W    = IMEM_DATA_W,
  parameter logic [7:0] SYNC_BYTE = LOAD_SYNC_BYTE,
  parameter int         TIMEOUT   = 50000
) (
  input  logic              clk,
  input  logic              rst_n,
  prog_load_ctrl_if.slave   rx,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              cpu_hold,
  output logic              cpu_rst,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_HI,
    S_LO,
    S_WRITE,
    S_RELEASE
  } state_t;

  state_t          state;
  logic [ADDR_W:0] words_left;
  logic            in_frame;
  logic            xfer;
  logic            timer_clear;
  logic            timer_en;
  logic            timed_out;

  // only the byte-collecting states are subject to the idle timeout
  assign in_frame    = (state == S_LEN) || (state == S_HI) || (state == S_LO);
  assign rx.rx_ready = rst_n && (in_frame || (state == S_IDLE));
  assign xfer        = rx.rx_valid && rx.rx_ready;
  assign timer_clear = !in_frame || xfer;
  assign timer_en    = in_frame && !xfer;

  idle_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_idle_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (timer_clear),
    .enable  (timer_en),
    .expired (timed_out)
  );

  // frame parser; cpu_hold is registered from the next state so it equals (state!=IDLE || err)
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      words_left <= '0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      cpu_hold   <= 1'b0;
      cpu_rst    <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      mem_we  <= 1'b0;
      cpu_rst <= 1'b0;
      done    <= 1'b0;
      case (state)
        S_IDLE: begin
          if (xfer && (rx.rx_data == SYNC_BYTE)) begin
            err      <= 1'b0;
            cpu_hold <= 1'b1;
            state    <= S_LEN;
          end else begin
            cpu_hold <= err;
          end
        end
        S_LEN: begin
          if (xfer) begin
            // a zero length byte means a full-depth image
            words_left <= (rx.rx_data == 8'd0) ? (ADDR_W+1)'(2**ADDR_W)
                                               : (ADDR_W+1)'(rx.rx_data);
            mem_addr   <= '0;
            state      <= S_HI;
          end else if (timed_out) begin
            err   <= 1'b1;
            state <= S_IDLE;
          end
        end
        S_HI: begin
          if (xfer) begin
            mem_wdata[DATA_W-1 -: 8] <= rx.rx_data;
            state                    <= S_LO;
          end else if (timed_out) begin
            err   <= 1'b1;
            state <= S_IDLE;
          end
        end
        S_LO: begin
          if (xfer) begin
            mem_wdata[7:0] <= rx.rx_data;
            mem_we         <= 1'b1;
            state          <= S_WRITE;
          end else if (timed_out) begin
            err   <= 1'b1;
            state <= S_IDLE;
          end
        end
        S_WRITE: begin
          mem_addr   <= mem_addr + 1'b1;
          words_left <= words_left - 1'b1;
          if (words_left == (ADDR_W+1)'(1)) begin
            cpu_rst <= 1'b1;
            done    <= 1'b1;
            state   <= S_RELEASE;
          end else begin
            state <= S_HI;
          end
        end
        S_RELEASE: begin
          cpu_hold <= err;
          state    <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prog_load_ctrl.sv
// tb/tb_prog_load_ctrl.sv - directed self-checking bench for prog_load_ctrl
module tb_prog_load_ctrl;

  localparam int TO = 200;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic        cpu_hold;
  logic        cpu_rst;
  logic        done;
  logic        err;

  int checks = 0;
  int errors = 0;
  int rst_pulses = 0;
  int pulses_before;

  logic [7:0]  wr_addr_q[$];
  logic [15:0] wr_data_q[$];
  logic [15:0] exp_q[$];

  always #5 clk = ~clk;

  prog_load_ctrl_if rx_bus ();

  prog_load_ctrl #(
    .TIMEOUT (TO)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx        (rx_bus.slave),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .cpu_hold  (cpu_hold),
    .cpu_rst   (cpu_rst),
    .done      (done),
    .err       (err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // write/pulse monitor sampled on the falling edge
  always @(negedge clk) begin
    if (rst_n && mem_we) begin
      wr_addr_q.push_back(mem_addr);
      wr_data_q.push_back(mem_wdata);
    end
    if (rst_n && cpu_rst) rst_pulses++;
    if (rst_n && (cpu_rst || done)) check("done_with_cpu_rst", {31'd0, done}, {31'd0, cpu_rst});
  end

  // present a byte and hold it until the loader accepts it; rx_valid stays high afterwards
  task automatic send_byte(input logic [7:0] b);
    int n;
    rx_bus.rx_valid = 1'b1;
    rx_bus.rx_data  = b;
    n = 0;
    while (!rx_bus.rx_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!rx_bus.rx_ready) check("rx_ready_wait", 32'd0, 32'd1);
    @(negedge clk);
  endtask

  task automatic wait_release();
    int n;
    n = 0;
    while (cpu_hold && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("release_wait", {31'd0, cpu_hold}, 32'd0);
  endtask

  task automatic check_frame(input string tag);
    int m;
    check({tag, "_writes"}, wr_data_q.size(), exp_q.size());
    m = (wr_data_q.size() < exp_q.size()) ? wr_data_q.size() : exp_q.size();
    for (int i = 0; i < m; i++) begin
      check({tag, "_addr"}, {24'd0, wr_addr_q[i]}, i % 256);
      check({tag, "_data"}, {16'd0, wr_data_q[i]}, {16'd0, exp_q[i]});
    end
    wr_addr_q.delete();
    wr_data_q.delete();
    exp_q.delete();
  endtask

  initial begin
    logic [7:0] hi;
    logic [7:0] lo;
    rx_bus.rx_valid = 1'b0;
    rx_bus.rx_data  = 8'h00;

    // reset state
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_rx_ready", {31'd0, rx_bus.rx_ready}, 32'd0);
    check("rst_outputs", {mem_we, cpu_hold, cpu_rst, done, err}, 32'd0);
    check("rst_addr_data", {8'd0, mem_addr, mem_wdata}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_rx_ready", {31'd0, rx_bus.rx_ready}, 32'd1);
    check("idle_hold", {31'd0, cpu_hold}, 32'd0);

    // test 1: two-word frame with exact release latency
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h12);
    send_byte(8'h34); send_byte(8'hAB); send_byte(8'hCD);
    rx_bus.rx_valid = 1'b0;
    check("t1_we", {31'd0, mem_we}, 32'd1);
    check("t1_last_addr", {24'd0, mem_addr}, 32'd1);
    check("t1_last_data", {16'd0, mem_wdata}, 32'h0000ABCD);
    check("t1_rx_ready_write", {31'd0, rx_bus.rx_ready}, 32'd0);
    @(negedge clk);
    check("t1_cpu_rst", {cpu_rst, done, cpu_hold}, 32'd7);
    check("t1_rx_ready_release", {31'd0, rx_bus.rx_ready}, 32'd0);
    @(negedge clk);
    check("t1_released", {cpu_rst, done, cpu_hold}, 32'd0);
    exp_q = '{16'h1234, 16'hABCD};
    check_frame("t1");
    check("t1_pulses", rst_pulses, 32'd1);

    // test 2: garbage before sync is dropped
    send_byte(8'h00); send_byte(8'hFF);
    check("t2_hold_before_sync", {cpu_hold, err}, 32'd0);
    send_byte(8'hA5);
    check("t2_hold_after_sync", {31'd0, cpu_hold}, 32'd1);
    send_byte(8'h01); send_byte(8'hC0); send_byte(8'h00);
    rx_bus.rx_valid = 1'b0;
    wait_release();
    exp_q = '{16'hC000};
    check_frame("t2");
    check("t2_pulses", rst_pulses, 32'd2);

    // test 3: length 0 loads 256 words, sync value inside data is plain data
    send_byte(8'hA5); send_byte(8'h00);
    for (int i = 0; i < 256; i++) begin
      hi = 8'(i);
      lo = 8'(i) ^ 8'h5A;
      exp_q.push_back({hi, lo});
      send_byte(hi);
      send_byte(lo);
    end
    rx_bus.rx_valid = 1'b0;
    wait_release();
    check("t3_final_addr", {24'd0, mem_addr}, 32'd0);
    check_frame("t3");
    check("t3_pulses", rst_pulses, 32'd3);

    // test 4: stall inside a frame aborts with sticky err
    pulses_before = rst_pulses;
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h11);
    rx_bus.rx_valid = 1'b0;
    repeat (TO - 1) @(negedge clk);
    check("t4_err_early", {err, cpu_hold}, 32'd1);
    repeat (4) @(negedge clk);
    check("t4_err_set", {err, cpu_hold}, 32'd3);
    check("t4_idle_ready", {31'd0, rx_bus.rx_ready}, 32'd1);
    repeat (3) @(negedge clk);
    check("t4_err_sticky", {err, cpu_hold, mem_we}, 32'd6);
    check("t4_no_writes", wr_data_q.size(), 32'd0);
    check("t4_no_pulse", rst_pulses, pulses_before);
    send_byte(8'hA5);
    check("t4_err_cleared", {err, cpu_hold}, 32'd1);
    send_byte(8'h01); send_byte(8'h55); send_byte(8'h66);
    rx_bus.rx_valid = 1'b0;
    wait_release();
    exp_q = '{16'h5566};
    check_frame("t4");

    // test 6: reset mid-word aborts silently, then a clean load
    pulses_before = rst_pulses;
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h12);
    rx_bus.rx_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    check("t6_rst_ready", {31'd0, rx_bus.rx_ready}, 32'd0);
    check("t6_rst_outputs", {mem_we, cpu_hold, cpu_rst, done, err}, 32'd0);
    check("t6_rst_addr_data", {8'd0, mem_addr, mem_wdata}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("t6_after_rst", {cpu_hold, err, rx_bus.rx_ready}, 32'd1);
    check("t6_no_pulse", rst_pulses, pulses_before);
    send_byte(8'hA5); send_byte(8'h03);
    send_byte(8'h01); send_byte(8'h02);
    send_byte(8'h03); send_byte(8'h04);
    send_byte(8'hA5); send_byte(8'hA5);
    rx_bus.rx_valid = 1'b0;
    wait_release();
    exp_q = '{16'h0102, 16'h0304, 16'hA5A5};
    check_frame("t6");
    check("t6_pulses", rst_pulses, pulses_before + 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
